// File: rtl/xillybus_pack_32to128_pkg.sv
// Shared widths and helpers for the 32-to-128 bit packer.
package xillybus_pack_32to128_pkg;
  localparam int SRC_W  = 32;
  localparam int DST_W  = 128;
  localparam int LANES  = 4;
  localparam int QDEPTH = 2;
  localparam int LANE_W = $clog2(LANES);
  localparam int CNT_W  = $clog2(QDEPTH + 1);

  typedef logic [SRC_W-1:0]  src_word_t;
  typedef logic [DST_W-1:0]  dst_word_t;
  typedef logic [LANE_W-1:0] lane_t;
  typedef logic [CNT_W-1:0]  qcnt_t;

  // Keep lanes [0, n) of a packed word and zero the rest.
  function automatic dst_word_t keep_lanes(dst_word_t w, lane_t n);
    dst_word_t m;
    m = w;
    for (int i = 0; i < LANES; i++) begin
      if (i >= int'(n)) m[i*SRC_W +: SRC_W] = '0;
    end
    return m;
  endfunction
endpackage

// File: rtl/pack_out_q2.sv
// Two-entry in-order output queue; head entry is presented combinationally.
module pack_out_q2
  import xillybus_pack_32to128_pkg::*;
(
  input  logic      clk,
  input  logic      srst,
  input  logic      push,
  input  dst_word_t push_data,
  input  logic      pop,
  output dst_word_t data,
  output qcnt_t     count,
  output logic      empty_n
);
  dst_word_t   mem_q [QDEPTH];
  dst_word_t   mem_d [QDEPTH];
  logic  [0:0] wr_ptr_q, wr_ptr_d;
  logic  [0:0] rd_ptr_q, rd_ptr_d;
  qcnt_t       count_q, count_d;
  logic        push_ok, pop_ok;

  always_comb begin
    pop_ok   = pop && (count_q != '0);
    // A full queue can still take a push when the head leaves in the same cycle.
    push_ok  = push && ((count_q < qcnt_t'(QDEPTH)) || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  generate
    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (srst) mem_q[gi] <= '0;
        else      mem_q[gi] <= mem_d[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign data    = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign empty_n = (count_q != '0);
endmodule

// File: rtl/xillybus_pack_32to128.sv
// Packs four 32-bit FWFT words into one 128-bit word (little-endian lanes),
// with an explicit flush that emits a zero-padded partial word.
module xillybus_pack_32to128
  import xillybus_pack_32to128_pkg::*;
(
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic [SRC_W-1:0] src_dout,
  input  logic             src_empty_n,
  output logic             src_read,
  output logic [DST_W-1:0] dst_dout,
  output logic             dst_empty_n,
  input  logic             dst_read,
  input  logic             flush,
  output logic [31:0]      words_out
);
  lane_t       lane_q, lane_d;
  dst_word_t   acc_q, acc_d;
  logic        flush_pending_q, flush_pending_d;
  logic [31:0] words_out_q, words_out_d;

  qcnt_t       q_count;
  logic        q_push, q_pop, service;
  dst_word_t   q_push_data;

  localparam lane_t LAST_LANE = lane_t'(LANES - 1);

  always_comb begin
    // Gated by reset so nothing is popped upstream while state is being cleared.
    src_read = !ap_rst && src_empty_n && !flush_pending_q &&
               ((lane_q != LAST_LANE) || (q_count < qcnt_t'(QDEPTH)));
    service  = flush_pending_q && (q_count < qcnt_t'(QDEPTH));
    q_pop    = dst_read && dst_empty_n;

    lane_d      = lane_q;
    acc_d       = acc_q;
    q_push      = 1'b0;
    q_push_data = '0;

    if (src_read) begin
      acc_d[int'(lane_q)*SRC_W +: SRC_W] = src_dout;
      if (lane_q == LAST_LANE) begin
        q_push      = 1'b1;
        q_push_data = {src_dout, acc_q[DST_W-SRC_W-1:0]};
        acc_d       = '0;
        lane_d      = '0;
      end else begin
        lane_d = lane_q + 1'b1;
      end
    end

    // src_read is held low while a flush is pending, so this never races the path above.
    if (service) begin
      if (lane_q != '0) begin
        q_push      = 1'b1;
        q_push_data = keep_lanes(acc_q, lane_q);
      end
      acc_d  = '0;
      lane_d = '0;
    end

    flush_pending_d = (flush_pending_q && !service) || flush;
    words_out_d     = q_pop ? words_out_q + 32'd1 : words_out_q;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      lane_q          <= '0;
      acc_q           <= '0;
      flush_pending_q <= 1'b0;
      words_out_q     <= '0;
    end else begin
      lane_q          <= lane_d;
      acc_q           <= acc_d;
      flush_pending_q <= flush_pending_d;
      words_out_q     <= words_out_d;
    end
  end

  pack_out_q2 u_q (
    .clk       (ap_clk),
    .srst      (ap_rst),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .data      (dst_dout),
    .count     (q_count),
    .empty_n   (dst_empty_n)
  );

  assign words_out = words_out_q;
endmodule

// File: tb/tb_xillybus_pack_32to128.sv
// Directed bench for the 32-to-128 packer; expected words go through a scoreboard queue.
module tb_xillybus_pack_32to128;
  logic         ap_clk = 1'b0;
  logic         ap_rst = 1'b1;
  logic [31:0]  src_dout = '0;
  logic         src_empty_n = 1'b0;
  logic         src_read;
  logic [127:0] dst_dout;
  logic         dst_empty_n;
  logic         dst_read = 1'b0;
  logic         flush = 1'b0;
  logic [31:0]  words_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0]  src_q [$];
  logic [127:0] sb [$];

  always #5 ap_clk = ~ap_clk;

  xillybus_pack_32to128 dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .src_dout    (src_dout),
    .src_empty_n (src_empty_n),
    .src_read    (src_read),
    .dst_dout    (dst_dout),
    .dst_empty_n (dst_empty_n),
    .dst_read    (dst_read),
    .flush       (flush),
    .words_out   (words_out)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    src_empty_n = (src_q.size() != 0);
    src_dout    = (src_q.size() != 0) ? src_q[0] : 32'h0;
  endtask

  task automatic settle();
    drive_src();
    #1;
  endtask

  // One clock cycle: check any pop against the scoreboard, then advance the source FIFO model.
  task automatic step();
    logic pop_now, rd_now;
    drive_src();
    #1;
    pop_now = dst_read && dst_empty_n;
    rd_now  = src_read;
    if (pop_now) begin
      if (sb.size() == 0) chk("pop_without_expected_word", {127'b0, pop_now}, 128'd0);
      else                chk("dst_dout", dst_dout, sb.pop_front());
    end
    @(posedge ap_clk);
    #1;
    if (rd_now && src_q.size() != 0) void'(src_q.pop_front());
    flush = 1'b0;
    drive_src();
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int b;
    b = budget;
    while (sb.size() != 0 && b > 0) begin
      step();
      b--;
    end
    chk(tag, 128'(sb.size()), 128'd0);
  endtask

  task automatic push_word4(input logic [31:0] base);
    for (int i = 0; i < 4; i++) src_q.push_back(base + 32'(i));
    sb.push_back({base + 32'd3, base + 32'd2, base + 32'd1, base});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, with source data already waiting.
    step();
    step();
    src_q.push_back(32'h11111111);
    src_q.push_back(32'h22222222);
    src_q.push_back(32'h33333333);
    src_q.push_back(32'h44444444);
    sb.push_back(128'h44444444_33333333_22222222_11111111);
    settle();
    chk("rst_src_read", 128'(src_read), 128'd0);
    chk("rst_dst_empty_n", 128'(dst_empty_n), 128'd0);
    chk("rst_dst_dout", dst_dout, 128'd0);
    chk("rst_words_out", 128'(words_out), 128'd0);

    // Basic packing.
    ap_rst   = 1'b0;
    dst_read = 1'b1;
    settle();
    chk("basic_src_read", 128'(src_read), 128'd1);
    step(); step(); step();
    chk("basic_not_valid_before_4th", 128'(dst_empty_n), 128'd0);
    step();
    chk("basic_valid_after_4th", 128'(dst_empty_n), 128'd1);
    step();
    chk("basic_words_out", 128'(words_out), 128'd1);

    // Backpressure: 12 words offered, only 11 fit (two full words queued, lane 3 pending).
    dst_read = 1'b0;
    for (int w = 0; w < 3; w++) push_word4(32'hB000_0000 + 32'(w * 4));
    for (int i = 0; i < 14; i++) step();
    chk("bp_src_read_low", 128'(src_read), 128'd0);
    chk("bp_accepted_11", 128'(src_q.size()), 128'd1);
    chk("bp_lane", 128'(dut.lane_q), 128'd3);
    chk("bp_count", 128'(dut.q_count), 128'd2);
    chk("bp_head", dst_dout, sb[0]);
    dst_read = 1'b1;
    settle();
    chk("bp_no_read_in_pop_cycle", 128'(src_read), 128'd0);
    step();
    chk("bp_read_after_pop", 128'(src_read), 128'd1);
    drain("bp_drain", 20);
    chk("bp_words_out", 128'(words_out), 128'd4);

    // Flush of a two-lane partial word.
    src_q.push_back(32'hAAAA0001);
    src_q.push_back(32'hAAAA0002);
    settle();
    step(); step();
    flush = 1'b1;
    sb.push_back(128'h00000000_00000000_AAAA0002_AAAA0001);
    step();
    chk("flush_not_yet_pushed", 128'(dst_empty_n), 128'd0);
    step();
    chk("flush_pushed", 128'(dst_empty_n), 128'd1);
    drain("flush_drain", 5);
    chk("flush_words_out", 128'(words_out), 128'd5);

    // Flush at lane 0 emits nothing.
    flush = 1'b1;
    step(); step(); step();
    chk("flush_lane0_empty", 128'(dst_empty_n), 128'd0);
    chk("flush_lane0_words_out", 128'(words_out), 128'd5);

    // Word accepted in the flush cycle belongs to the flushed word.
    src_q.push_back(32'hAAAA0003);
    src_q.push_back(32'hAAAA0004);
    flush = 1'b1;
    sb.push_back({96'd0, 32'hAAAA0003});
    step();
    chk("flush_suppresses_read", 128'(src_read), 128'd0);
    step();
    chk("flush_read_resumes", 128'(src_read), 128'd1);
    step();
    flush = 1'b1;
    sb.push_back({96'd0, 32'hAAAA0004});
    step(); step();
    drain("flush_same_cycle_drain", 8);
    chk("flush_same_cycle_words_out", 128'(words_out), 128'd7);

    // Flush while the queue is full: serviced only in the cycle after the first pop.
    dst_read = 1'b0;
    push_word4(32'hC000_0000);
    push_word4(32'hC000_0004);
    src_q.push_back(32'hC0000008);
    sb.push_back({96'd0, 32'hC0000008});
    for (int i = 0; i < 12; i++) step();
    chk("fullq_lane", 128'(dut.lane_q), 128'd1);
    chk("fullq_count", 128'(dut.q_count), 128'd2);
    flush = 1'b1;
    step();
    src_q.push_back(32'hD0000001);
    settle();
    chk("fullq_read_held", 128'(src_read), 128'd0);
    step(); step();
    chk("fullq_read_still_held", 128'(src_read), 128'd0);
    dst_read = 1'b1;
    step();
    dst_read = 1'b0;
    chk("fullq_no_service_in_pop_cycle", 128'(dut.q_count), 128'd1);
    chk("fullq_pending_in_service_cycle", 128'(src_read), 128'd0);
    step();
    chk("fullq_partial_pushed", 128'(dut.q_count), 128'd2);
    chk("fullq_read_after_service", 128'(src_read), 128'd1);
    dst_read = 1'b1;
    step();
    flush = 1'b1;
    sb.push_back({96'd0, 32'hD0000001});
    step(); step();
    drain("fullq_drain", 12);
    chk("fullq_words_out", 128'(words_out), 128'd11);

    // Reset mid-packet discards the queued word and the partial accumulator.
    dst_read = 1'b0;
    for (int i = 0; i < 6; i++) src_q.push_back(32'hE000_0000 + 32'(i));
    settle();
    for (int i = 0; i < 8; i++) step();
    chk("midrst_lane_before", 128'(dut.lane_q), 128'd2);
    chk("midrst_count_before", 128'(dut.q_count), 128'd1);
    ap_rst = 1'b1;
    step();
    chk("midrst_dst_empty_n", 128'(dst_empty_n), 128'd0);
    chk("midrst_dst_dout", dst_dout, 128'd0);
    chk("midrst_words_out", 128'(words_out), 128'd0);
    chk("midrst_src_read", 128'(src_read), 128'd0);
    ap_rst   = 1'b0;
    dst_read = 1'b1;
    push_word4(32'hF000_0000);
    settle();
    drain("midrst_clean_word", 10);
    chk("midrst_words_out_after", 128'(words_out), 128'd1);

    // words_out wraps to zero.
    force dut.words_out_q = 32'hFFFF_FFFF;
    #1;
    release dut.words_out_q;
    chk("wrap_preload", 128'(words_out), 128'hFFFF_FFFF);
    push_word4(32'h5000_0000);
    settle();
    drain("wrap_drain", 10);
    chk("wrap_words_out", 128'(words_out), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
